// File: rtl/mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// mul_sequencer_if
// Handshake and data bundle between the decode/control unit (master) and the
// multiply sequencer (slave).
//   start/flush          : operation request / synchronous abort
//   op, rm, rs           : operation code, multiplicand, multiplier
//   acc_lo, acc_hi       : accumulator words
//   busy, done           : status and one-cycle completion strobe
//   res_lo, res_hi       : 64-bit result (res_hi is 0 for short ops)
//   n_flag, z_flag       : negative / zero flags of the result
// ---------------------------------------------------------------------------
interface mul_sequencer_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rm;
  logic [31:0] rs;
  logic [31:0] acc_lo;
  logic [31:0] acc_hi;
  logic        busy;
  logic        done;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        n_flag;
  logic        z_flag;

  modport master (
    output start, flush, op, rm, rs, acc_lo, acc_hi,
    input  busy, done, res_lo, res_hi, n_flag, z_flag
  );

  modport slave (
    input  start, flush, op, rm, rs, acc_lo, acc_hi,
    output busy, done, res_lo, res_hi, n_flag, z_flag
  );
endinterface

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL engine. Consumes CHUNK (8)
// multiplier bits per cycle with early termination, adds the accumulator in
// an optional extra cycle and reports N/Z flags with a one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mul_sequencer_if.slave (start/flush/op/rm/rs/acc_* in,
//          busy/done/res_lo/res_hi/n_flag/z_flag out, all outputs registered)
// ---------------------------------------------------------------------------
module mul_sequencer #(
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       res_lo_r;
  logic [31:0]       res_hi_r;
  logic              n_r;
  logic              z_r;

  logic              long_r;      // 64-bit result
  logic              acc_en_r;    // accumulate cycle required
  logic              sgn_last_r;  // final chunk is weighted as signed
  logic [1:0]        cnt_r;       // current chunk index
  logic [1:0]        last_r;      // index of the terminating chunk (k-1)
  logic [63:0]       mcand_r;     // multiplicand, pre-shifted by CHUNK*cnt
  logic [31:0]       mplier_r;    // multiplier, consumed from the bottom
  logic [63:0]       prod_r;      // running partial sum
  logic [63:0]       acc_r;       // accumulator, already widened

  logic [CHUNK-1:0]  chunk_s;
  logic              neg_s;
  logic [63:0]       partial_s;
  logic [63:0]       mul_sum_s;
  logic [63:0]       acc_sum_s;
  logic [63:0]       fin_src_s;
  logic [31:0]       fin_lo_s;
  logic [31:0]       fin_hi_s;
  logic              fin_n_s;
  logic              fin_z_s;

  // Index of the last chunk needed. Unsigned long stops once the remaining
  // upper bits are zero; every other op stops once they are pure sign bits,
  // so the last chunk can be treated as signed without losing information.
  function automatic logic [1:0] calc_last(input logic [31:0] rs, input logic uns_long);
    logic [1:0] k_m1;
    if (uns_long) begin
      if (rs[31:8] == 24'd0)       k_m1 = 2'd0;
      else if (rs[31:16] == 16'd0) k_m1 = 2'd1;
      else if (rs[31:24] == 8'd0)  k_m1 = 2'd2;
      else                         k_m1 = 2'd3;
    end else begin
      if ((rs[31:7] == {25{1'b0}}) || (rs[31:7] == {25{1'b1}}))       k_m1 = 2'd0;
      else if ((rs[31:15] == {17{1'b0}}) || (rs[31:15] == {17{1'b1}})) k_m1 = 2'd1;
      else if ((rs[31:23] == {9{1'b0}}) || (rs[31:23] == {9{1'b1}}))   k_m1 = 2'd2;
      else                                                             k_m1 = 2'd3;
    end
    return k_m1;
  endfunction

  // Partial product and the candidate final result for this cycle.
  // A negative signed last chunk c-256 is realised as c*m - (m << CHUNK).
  always_comb begin
    chunk_s   = mplier_r[CHUNK-1:0];
    neg_s     = sgn_last_r && (cnt_r == last_r) && chunk_s[CHUNK-1];
    partial_s = (mcand_r * {{(64-CHUNK){1'b0}}, chunk_s})
              - (neg_s ? {mcand_r[63-CHUNK:0], {CHUNK{1'b0}}} : 64'd0);
    mul_sum_s = prod_r + partial_s;
    acc_sum_s = prod_r + acc_r;
    fin_src_s = (state_r == ST_ACC) ? acc_sum_s : mul_sum_s;
    fin_lo_s  = fin_src_s[31:0];
    fin_hi_s  = long_r ? fin_src_s[63:32] : 32'd0;
    fin_n_s   = long_r ? fin_src_s[63] : fin_src_s[31];
    fin_z_s   = ({fin_hi_s, fin_lo_s} == 64'd0);
  end

  // Sequencer FSM: operand capture, shift-add iterations, accumulate, done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      res_lo_r   <= 32'd0;
      res_hi_r   <= 32'd0;
      n_r        <= 1'b0;
      z_r        <= 1'b0;
      long_r     <= 1'b0;
      acc_en_r   <= 1'b0;
      sgn_last_r <= 1'b0;
      cnt_r      <= 2'd0;
      last_r     <= 2'd0;
      mcand_r    <= 64'd0;
      mplier_r   <= 32'd0;
      prod_r     <= 64'd0;
      acc_r      <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start && !bus.flush) begin
            state_r    <= ST_MUL;
            busy_r     <= 1'b1;
            long_r     <= bus.op[2];
            acc_en_r   <= bus.op[0];
            sgn_last_r <= !(bus.op[2] && !bus.op[1]);
            last_r     <= calc_last(bus.rs, bus.op[2] && !bus.op[1]);
            cnt_r      <= 2'd0;
            // Only signed long needs the multiplicand sign-extended; short
            // results are taken mod 2^32 so the upper half is irrelevant.
            mcand_r    <= (bus.op[2] && bus.op[1]) ? {{32{bus.rm[31]}}, bus.rm}
                                                   : {32'd0, bus.rm};
            mplier_r   <= bus.rs;
            prod_r     <= 64'd0;
            acc_r      <= bus.op[2] ? {bus.acc_hi, bus.acc_lo} : {32'd0, bus.acc_lo};
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            prod_r   <= mul_sum_s;
            mcand_r  <= {mcand_r[63-CHUNK:0], {CHUNK{1'b0}}};
            mplier_r <= {{CHUNK{1'b0}}, mplier_r[31:CHUNK]};
            cnt_r    <= cnt_r + 2'd1;
            if (cnt_r == last_r) begin
              if (acc_en_r) begin
                state_r <= ST_ACC;
              end else begin
                state_r  <= ST_DONE;
                busy_r   <= 1'b0;
                done_r   <= 1'b1;
                res_lo_r <= fin_lo_s;
                res_hi_r <= fin_hi_s;
                n_r      <= fin_n_s;
                z_r      <= fin_z_s;
              end
            end else begin
              state_r <= ST_MUL;
            end
          end
        end
        ST_ACC: begin
          if (bus.flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            res_lo_r <= fin_lo_s;
            res_hi_r <= fin_hi_s;
            n_r      <= fin_n_s;
            z_r      <= fin_z_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.res_lo = res_lo_r;
  assign bus.res_hi = res_hi_r;
  assign bus.n_flag = n_r;
  assign bus.z_flag = z_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_sequencer
// Directed vectors with hand-computed results. Stimulus pushes the expected
// result into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever done is high. Timing, flush and reset behaviour are
// checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mul_sequencer;

  typedef struct {
    logic [63:0] val;
    logic        n;
    logic        z;
    int          id;
  } exp_t;

  logic clk;
  logic rst;
  mul_sequencer_if bus();

  mul_sequencer #(.CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          pushed    = 0;
  int          done_seen = 0;
  logic [63:0] last_val  = 64'd0;
  logic        last_n    = 1'b0;
  logic        last_z    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      done_seen = done_seen + 1;
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check({bus.res_hi, bus.res_lo} == e.val, $sformatf("result_%0d", e.id),
              {bus.res_hi, bus.res_lo}, e.val);
        check({bus.n_flag, bus.z_flag} == {e.n, e.z}, $sformatf("flags_nz_%0d", e.id),
              {62'd0, bus.n_flag, bus.z_flag}, {62'd0, e.n, e.z});
      end
    end
  end

  // Present an operation; the start is sampled at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] alo, input logic [31:0] ahi,
                       input logic [63:0] val, input logic n, input logic z,
                       input bit expect_done);
    exp_t e;
    bus.op     = op;
    bus.rm     = rm;
    bus.rs     = rs;
    bus.acc_lo = alo;
    bus.acc_hi = ahi;
    bus.start  = 1'b1;
    if (expect_done) begin
      e.val = val; e.n = n; e.z = z; e.id = pushed;
      sb_q.push_back(e);
      pushed   = pushed + 1;
      last_val = val; last_n = n; last_z = z;
    end
  endtask

  // Consume the accepting edge, then count cycles until done (bounded).
  task automatic wait_done(input int exp_lat, input bit keep_start, input string name);
    int  n;
    bit  busy_bad;
    bit  seen;
    n = 0; busy_bad = 1'b0; seen = 1'b0;
    @(posedge clk); #1;
    if (!keep_start) bus.start = 1'b0;
    // Scramble inputs after capture; the result must not depend on them.
    bus.rm = 32'hA5A5_5A5A; bus.rs = 32'h1234_5678; bus.acc_lo = 32'hFFFF_0000; bus.acc_hi = 32'h0000_FFFF;
    n = 1;
    while (n <= 12 && !seen) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (!bus.busy) busy_bad = 1'b1;
        @(posedge clk); #1;
        n = n + 1;
      end
    end
    bus.start = 1'b0;
    check(seen, {name, "_done_timeout"}, {63'd0, seen}, 64'd1);
    check(n == exp_lat, {name, "_latency"}, n, exp_lat);
    check(!busy_bad && !bus.busy, {name, "_busy"}, {62'd0, busy_bad, bus.busy}, 64'd0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                     input logic [31:0] alo, input logic [31:0] ahi,
                     input logic [63:0] val, input logic n, input logic z,
                     input int lat, input string name);
    issue(op, rm, rs, alo, ahi, val, n, z, 1'b1);
    wait_done(lat, 1'b0, name);
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.rm = 32'd0; bus.rs = 32'd0; bus.acc_lo = 32'd0; bus.acc_hi = 32'd0;
    rst = 1'b1;
    #12;
    check({bus.busy, bus.done, bus.n_flag, bus.z_flag} == 4'd0, "reset_status",
          {60'd0, bus.busy, bus.done, bus.n_flag, bus.z_flag}, 64'd0);
    check({bus.res_hi, bus.res_lo} == 64'd0, "reset_result", {bus.res_hi, bus.res_lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back group: each start is presented in the previous DONE cycle.
    run(3'b000, 32'd3,          32'd5,          32'd0, 32'd0, 64'h0000_0000_0000_000F, 1'b0, 1'b0, 2, "mul_3x5");
    run(3'b100, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0, 32'd0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, 5, "umull_max");
    run(3'b110, 32'hFFFF_FFFE,  32'd3,          32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0, 2, "smull_m2x3");
    run(3'b110, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0, 32'd0, 64'h0000_0000_0000_0002, 1'b0, 1'b0, 2, "smull_m2xm1");
    run(3'b001, 32'd0,          32'h0000_0100,  32'd0, 32'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 4, "mla_zero");
    idle(1);
    run(3'b101, 32'd1,          32'd1,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 1'b1, 3, "umlal_wrap");
    idle(1);
    run(3'b000, 32'd7,          32'hFFFF_FFFE,  32'd0, 32'd0, 64'h0000_0000_FFFF_FFF2, 1'b1, 1'b0, 2, "mul_neg_rs");
    idle(2);
    run(3'b100, 32'h0001_0000,  32'h0000_0080,  32'd0, 32'd0, 64'h0000_0000_0080_0000, 1'b0, 1'b0, 2, "umull_k1_0x80");
    idle(1);
    run(3'b110, 32'hFFFF_FFFF,  32'h0000_0080,  32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 3, "smull_k2_0x80");
    idle(1);
    run(3'b001, 32'h1234_5678,  32'h0000_0010,  32'd1, 32'd0, 64'h0000_0000_2345_6781, 1'b0, 1'b0, 3, "mla_acc");
    idle(1);
    run(3'b101, 32'h8000_0000,  32'h0100_0000,  32'd5, 32'd1, 64'h0080_0001_0000_0005, 1'b0, 1'b0, 6, "umlal_k4");
    idle(1);
    run(3'b111, 32'h8000_0000,  32'h8000_0000,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 6, "smlal_min");
    idle(1);
    run(3'b010, 32'hFFFF_FFFF,  32'd2,          32'd0, 32'd0, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0, 2, "mul_sign_ignored");
    idle(1);
    run(3'b001, 32'd2,          32'd3,          32'd4, 32'hDEAD_BEEF, 64'h0000_0000_0000_000A, 1'b0, 1'b0, 3, "mla_hi_ignored");
    idle(1);

    // Start held high through the whole operation: exactly one done.
    issue(3'b000, 32'd2, 32'h0000_0100, 32'd0, 32'd0, 64'h0000_0000_0000_0200, 1'b0, 1'b0, 1'b1);
    wait_done(3, 1'b1, "start_held");
    idle(5);

    // Flush in the second MUL cycle of a k=4 UMULL.
    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1; bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check({bus.busy, bus.done} == 2'b00, "flush_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    idle(6);
    check({bus.res_hi, bus.res_lo} == last_val, "flush_hold_result", {bus.res_hi, bus.res_lo}, last_val);
    check({bus.n_flag, bus.z_flag} == {last_n, last_z}, "flush_hold_flags",
          {62'd0, bus.n_flag, bus.z_flag}, {62'd0, last_n, last_z});

    // Flush in IDLE suppresses a same-cycle start.
    issue(3'b000, 32'd1, 32'd1, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.flush = 1'b0;
    check(bus.busy == 1'b0, "flush_idle_suppress", {63'd0, bus.busy}, 64'd0);
    idle(4);

    // Asynchronous reset between edges while in MUL.
    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; bus.start = 1'b0;
    check(bus.busy == 1'b1, "pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check({bus.busy, bus.done, bus.n_flag, bus.z_flag} == 4'd0, "async_reset_status",
          {60'd0, bus.busy, bus.done, bus.n_flag, bus.z_flag}, 64'd0);
    check({bus.res_hi, bus.res_lo} == 64'd0, "async_reset_result", {bus.res_hi, bus.res_lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Normal operation after reset.
    run(3'b000, 32'd6, 32'd7, 32'd0, 32'd0, 64'h0000_0000_0000_002A, 1'b0, 1'b0, 2, "post_reset_mul");
    idle(4);

    check(done_seen == pushed, "done_count", done_seen, pushed);
    check(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
